// File: rtl/hwpe_stream_parity_fault_ctrl.sv
// Parity-network fault supervisor: sticky status, saturating counters, level irq, injection self-test.
// Recording lands one cycle after fault_i; inject_o is registered; no backpressure, every input is sampled each cycle.
module hwpe_stream_parity_fault_ctrl #(
  parameter int NB_CHAN   = 4,
  parameter int CNT_WIDTH = 8,
  parameter int TIMEOUT   = 16,
  localparam int CHAN_W   = (NB_CHAN > 1) ? $clog2(NB_CHAN) : 1
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         enable_i,
  input  logic                         clear_i,
  input  logic [NB_CHAN-1:0]           mask_i,
  input  logic [NB_CHAN-1:0]           fault_i,
  input  logic                         selftest_start_i,
  input  logic [CHAN_W-1:0]            selftest_chan_i,
  output logic [NB_CHAN-1:0]           inject_o,
  output logic [NB_CHAN-1:0]           status_o,
  output logic [NB_CHAN*CNT_WIDTH-1:0] count_o,
  output logic                         irq_o,
  output logic                         selftest_busy_o,
  output logic                         selftest_done_o,
  output logic                         selftest_pass_o
);

  localparam int TIMER_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, DONE = 2'd2} state_t;

  state_t               state_q, state_d;
  logic [CHAN_W-1:0]    chan_q, chan_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic                 pass_q, pass_d;
  logic [NB_CHAN-1:0]   inject_q, inject_d;
  logic                 chan_ok;
  logic [NB_CHAN-1:0]   record;
  logic [NB_CHAN-1:0]   status_q;
  logic [CNT_WIDTH-1:0] cnt_q [NB_CHAN];

  assign chan_ok = ({1'b0, selftest_chan_i} < (CHAN_W+1)'(NB_CHAN));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      chan_q   <= '0;
      timer_q  <= '0;
      pass_q   <= 1'b0;
      inject_q <= '0;
    end else begin
      state_q  <= state_d;
      chan_q   <= chan_d;
      timer_q  <= timer_d;
      pass_q   <= pass_d;
      inject_q <= inject_d;
    end
  end

  always_comb begin
    state_d = state_q;
    chan_d  = chan_q;
    timer_d = timer_q;
    pass_d  = pass_q;
    case (state_q)
      IDLE: begin
        if (selftest_start_i && enable_i) begin
          pass_d  = 1'b0;
          chan_d  = selftest_chan_i;
          timer_d = '0;
          state_d = chan_ok ? ARMED : DONE;
        end
      end
      ARMED: begin
        // Abort has priority: a disabled supervisor cannot vouch for the channel.
        if (!enable_i) begin
          state_d = DONE;
          pass_d  = 1'b0;
        end else if (fault_i[chan_q]) begin
          state_d = DONE;
          pass_d  = 1'b1;
        end else if (timer_q == TIMER_W'(TIMEOUT - 1)) begin
          state_d = DONE;
          pass_d  = 1'b0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    inject_d = '0;
    if (state_d == ARMED) inject_d[chan_d] = 1'b1;
    selftest_done_o = (state_q == DONE);
    selftest_busy_o = (state_q != IDLE);
    selftest_pass_o = pass_q;
    inject_o        = inject_q;
  end

  // inject_q is one-hot on the channel under test exactly while ARMED, so it doubles as the record mask.
  assign record = fault_i & ~inject_q & {NB_CHAN{enable_i}};

  for (genvar i = 0; i < NB_CHAN; i++) begin : g_chan
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        status_q[i] <= 1'b0;
        cnt_q[i]    <= '0;
      end else if (record[i]) begin
        status_q[i] <= 1'b1;
        if (clear_i)        cnt_q[i] <= CNT_WIDTH'(1);
        else if (!(&cnt_q[i])) cnt_q[i] <= cnt_q[i] + 1'b1;
      end else if (clear_i) begin
        status_q[i] <= 1'b0;
        cnt_q[i]    <= '0;
      end
    end
    assign count_o[i*CNT_WIDTH +: CNT_WIDTH] = cnt_q[i];
  end

  assign status_o = status_q;
  assign irq_o    = enable_i & (|(status_q & ~mask_i));

endmodule
